// File: rtl/interval_timer_if.sv
// Request/response bundle between the light FSM, the parameter store and the
// interval timer. The timer takes the slave side.
interface interval_timer_if #(
    parameter int WIDTH = 4
);
    // Handshake: Start_Timer is a one-cycle request that is taken only while Busy
    // is low and Cancel is low; Busy acts as the not-ready flag. Expired is a
    // one-cycle completion strobe.
    logic             Start_Timer;
    logic [1:0]       Req_Interval;
    logic             Cancel;
    logic             One_Hz_Enable;
    logic [WIDTH-1:0] Param_Value;
    logic [1:0]       Interval;
    logic [WIDTH-1:0] Remaining;
    logic             Busy;
    logic             Expired;

    modport master (
        output Start_Timer, Req_Interval, Cancel, One_Hz_Enable, Param_Value,
        input  Interval, Remaining, Busy, Expired
    );

    modport slave (
        input  Start_Timer, Req_Interval, Cancel, One_Hz_Enable, Param_Value,
        output Interval, Remaining, Busy, Expired
    );
endinterface

// File: rtl/interval_timer.sv
// Interval timer: selects a duration in the parameter store, loads it once the
// store answers, counts it down on 1 Hz ticks and strobes Expired at the end.
module interval_timer #(
    parameter int WIDTH         = 4,
    parameter int PARAM_LATENCY = 2
) (
    input  logic                clk,
    input  logic                Reset,
    interval_timer_if.slave     bus,
    output logic [1:0]          dbg_state
);
    localparam int CW = (PARAM_LATENCY < 2) ? 1 : $clog2(PARAM_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       interval_q, interval_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [CW-1:0]    fetch_cnt_q, fetch_cnt_d;
    logic             busy_q, busy_d;
    logic             expired_q, expired_d;

    always_comb begin
        state_d     = state_q;
        interval_d  = interval_q;
        remaining_d = remaining_q;
        fetch_cnt_d = fetch_cnt_q;

        case (state_q)
            S_IDLE: begin
                remaining_d = '0;
                if (bus.Start_Timer && (bus.Req_Interval != 2'b11)) begin
                    interval_d  = bus.Req_Interval;
                    fetch_cnt_d = CW'(PARAM_LATENCY);
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                // The store needs PARAM_LATENCY edges to answer the new select.
                fetch_cnt_d = fetch_cnt_q - 1'b1;
                if (fetch_cnt_q == CW'(1)) begin
                    remaining_d = bus.Param_Value;
                    state_d     = (bus.Param_Value == '0) ? S_DONE : S_COUNT;
                end
            end
            S_COUNT: begin
                if (bus.One_Hz_Enable) begin
                    if (remaining_q <= WIDTH'(1)) begin
                        remaining_d = '0;
                        state_d     = S_DONE;
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                    end
                end
            end
            S_DONE: begin
                remaining_d = '0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Cancel overrides everything, including a same-cycle Start.
        if (bus.Cancel) begin
            state_d     = S_IDLE;
            interval_d  = interval_q;
            remaining_d = '0;
            fetch_cnt_d = '0;
        end

        busy_d    = (state_d != S_IDLE);
        expired_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            interval_q  <= 2'b00;
            remaining_q <= '0;
            fetch_cnt_q <= '0;
            busy_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            interval_q  <= interval_d;
            remaining_q <= remaining_d;
            fetch_cnt_q <= fetch_cnt_d;
            busy_q      <= busy_d;
            expired_q   <= expired_d;
        end
    end

    assign bus.Interval  = interval_q;
    assign bus.Remaining = remaining_q;
    assign bus.Busy      = busy_q;
    assign bus.Expired   = expired_q;
    assign dbg_state     = state_q;
endmodule
